// File: rtl/temp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : temp_pkg
//  Purpose  : Shared types, default thresholds and the sample classifier
//             used by the temperature persistence front-end.
//  Contents : temp_t            - signed 11-bit scaled temperature
//             clase_t           - sample class (normal / cold / hot / invalid)
//             TEMP_*            - default threshold constants
//             clasificar_umbral - classifier with explicit thresholds
//             clasificar        - classifier using the default thresholds
//  Revision : 1.0 - initial release
// ============================================================================
package temp_pkg;

    typedef logic signed [10:0] temp_t;

    typedef enum logic [1:0] {
        C_NORMAL   = 2'd0,
        C_FRIO     = 2'd1,
        C_CALOR    = 2'd2,
        C_INVALIDA = 2'd3
    } clase_t;

    localparam int TEMP_BAJO = 180;
    localparam int TEMP_ALTO = 259;
    localparam int TEMP_MIN  = -400;
    localparam int TEMP_MAX  = 1250;

    // Plausibility is tested first so an out-of-range reading is never
    // mistaken for a cold or hot sample. The sample is widened to int with
    // sign extension so every comparison is signed.
    function automatic clase_t clasificar_umbral(
        input temp_t t,
        input int    bajo,
        input int    alto,
        input int    tmin,
        input int    tmax
    );
        int v;
        v = int'(t);
        if (v < tmin || v > tmax) return C_INVALIDA;
        if (v < bajo)             return C_FRIO;
        if (v > alto)             return C_CALOR;
        return C_NORMAL;
    endfunction

    function automatic clase_t clasificar(input temp_t t);
        return clasificar_umbral(t, TEMP_BAJO, TEMP_ALTO, TEMP_MIN, TEMP_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/persistencia_temp_if.sv
`default_nettype none
// ============================================================================
//  Module   : persistencia_temp_if
//  Purpose  : Sample-in / status-out bundle of the persistence front-end.
//  Modports : master - sample source (drives temp_in, temp_valid, clr_err)
//             slave  - persistencia_temp (drives registered sample and flags)
//  Params   : N_PERSIST - must match the block's N_PERSIST (sets counter width)
//  Revision : 1.0 - initial release
// ============================================================================
interface persistencia_temp_if
    import temp_pkg::*;
#(
    parameter int N_PERSIST = 8
) ();

    localparam int CNT_W = $clog2(N_PERSIST + 1);

    temp_t             temp_in;
    logic              temp_valid;
    logic              clr_err;
    temp_t             temp_registrado;
    logic              per_bajo;
    logic              per_alto;
    logic              falla_sensor;
    logic              err_sensor;
    logic [CNT_W-1:0]  cnt_bajo;
    logic [CNT_W-1:0]  cnt_alto;

    modport master (
        output temp_in, temp_valid, clr_err,
        input  temp_registrado, per_bajo, per_alto, falla_sensor, err_sensor,
               cnt_bajo, cnt_alto
    );

    modport slave (
        input  temp_in, temp_valid, clr_err,
        output temp_registrado, per_bajo, per_alto, falla_sensor, err_sensor,
               cnt_bajo, cnt_alto
    );

endinterface
`default_nettype wire

// File: rtl/persistencia_temp_contador.sv
`default_nettype none
// ============================================================================
//  Module   : contador_persist
//  Purpose  : Saturating run-length counter for consecutive qualifying
//             samples. clr has priority over inc.
//  Ports    : clk, arst_n (async, active-low)
//             inc   - count one more qualifying sample (saturates at N)
//             clr   - restart the run at 0
//             cnt   - current run length
//             lleno - run length has reached N
//  Revision : 1.0 - initial release
// ============================================================================
module contador_persist #(
    parameter int N = 8
) (
    input  wire logic                     clk,
    input  wire logic                     arst_n,
    input  wire logic                     inc,
    input  wire logic                     clr,
    output logic [$clog2(N+1)-1:0]        cnt,
    output logic                          lleno
);

    localparam int             W     = $clog2(N + 1);
    localparam logic [W-1:0]   C_MAX = W'(N);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != C_MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt   = r_cnt;
    assign lleno = (r_cnt == C_MAX);

endmodule
`default_nettype wire

// File: rtl/persistencia_temp.sv
`default_nettype none
// ============================================================================
//  Module   : persistencia_temp
//  Purpose  : Accepts temperature samples, keeps the last valid one, counts
//             consecutive cold/hot samples to raise per_bajo / per_alto, and
//             screens implausible readings into err_sensor / falla_sensor.
//  Ports    : clk, arst_n (async, active-low)
//             bus (slave):  temp_in, temp_valid, clr_err            -> in
//                           temp_registrado, per_bajo, per_alto,
//                           falla_sensor, err_sensor,
//                           cnt_bajo, cnt_alto                      -> out
//  Revision : 1.0 - initial release
// ============================================================================
module persistencia_temp #(
    parameter int TEMP_BAJO  = temp_pkg::TEMP_BAJO,
    parameter int TEMP_ALTO  = temp_pkg::TEMP_ALTO,
    parameter int TEMP_MIN   = temp_pkg::TEMP_MIN,
    parameter int TEMP_MAX   = temp_pkg::TEMP_MAX,
    parameter int N_PERSIST  = 8,
    parameter int ERR_MAX    = 4,
    parameter int TEMP_RESET = 220
) (
    input  wire logic          clk,
    input  wire logic          arst_n,
    persistencia_temp_if.slave bus
);

    import temp_pkg::*;

    localparam int                CW        = $clog2(N_PERSIST + 1);
    localparam int                EW        = $clog2(ERR_MAX + 1);
    localparam logic [CW-1:0]     C_N_M1    = CW'(N_PERSIST - 1);
    localparam logic [EW-1:0]     C_ERR_MAX = EW'(ERR_MAX);
    localparam logic [EW-1:0]     C_ERR_M1  = EW'(ERR_MAX - 1);

    clase_t          w_clase;
    logic            w_valida;
    logic            w_invalida;
    logic            w_falla_nueva;
    logic            w_inc_bajo, w_clr_bajo;
    logic            w_inc_alto, w_clr_alto;
    logic [CW-1:0]   w_cnt_bajo, w_cnt_alto;
    logic            w_lleno_bajo, w_lleno_alto;
    logic            w_per_bajo_next, w_per_alto_next;

    temp_t           r_temp;
    logic [EW-1:0]   r_err_cnt;
    logic            r_falla;
    logic            r_err;
    logic            r_per_bajo;
    logic            r_per_alto;

    // ------------------------------------------------------------------
    // Classification and counter control
    // ------------------------------------------------------------------
    always_comb begin
        w_clase    = clasificar_umbral(bus.temp_in, TEMP_BAJO, TEMP_ALTO,
                                       TEMP_MIN, TEMP_MAX);
        w_valida   = bus.temp_valid && (w_clase != C_INVALIDA);
        w_invalida = bus.temp_valid && (w_clase == C_INVALIDA);
        // The error run reaches (or is already at) ERR_MAX on this edge.
        // Re-firing once saturated is harmless: the counters are already 0.
        w_falla_nueva = w_invalida && (r_err_cnt >= C_ERR_M1);
    end

    // An invalid sample below the failure limit leaves both runs untouched,
    // which is what lets a short glitch sit inside a run without breaking it.
    assign w_inc_bajo = w_valida && (w_clase == C_FRIO);
    assign w_clr_bajo = (w_valida && (w_clase != C_FRIO)) || w_falla_nueva;
    assign w_inc_alto = w_valida && (w_clase == C_CALOR);
    assign w_clr_alto = (w_valida && (w_clase != C_CALOR)) || w_falla_nueva;

    contador_persist #(.N(N_PERSIST)) u_cnt_bajo (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (w_inc_bajo),
        .clr    (w_clr_bajo),
        .cnt    (w_cnt_bajo),
        .lleno  (w_lleno_bajo)
    );

    contador_persist #(.N(N_PERSIST)) u_cnt_alto (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (w_inc_alto),
        .clr    (w_clr_alto),
        .cnt    (w_cnt_alto),
        .lleno  (w_lleno_alto)
    );

    // Flags track "counter will equal N after this edge", reconstructed from
    // the counter's controls so the flag register lines up with the count.
    always_comb begin
        w_per_bajo_next = w_lleno_bajo;
        w_per_alto_next = w_lleno_alto;
        if (w_clr_bajo) begin
            w_per_bajo_next = 1'b0;
        end else if (w_inc_bajo) begin
            w_per_bajo_next = w_lleno_bajo || (w_cnt_bajo == C_N_M1);
        end
        if (w_clr_alto) begin
            w_per_alto_next = 1'b0;
        end else if (w_inc_alto) begin
            w_per_alto_next = w_lleno_alto || (w_cnt_alto == C_N_M1);
        end
    end

    // ------------------------------------------------------------------
    // Sample register, error logic and flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_temp     <= temp_t'(TEMP_RESET);
            r_err_cnt  <= '0;
            r_falla    <= 1'b0;
            r_err      <= 1'b0;
            r_per_bajo <= 1'b0;
            r_per_alto <= 1'b0;
        end else begin
            r_per_bajo <= w_per_bajo_next;
            r_per_alto <= w_per_alto_next;

            if (w_valida) begin
                r_temp    <= bus.temp_in;
                r_err_cnt <= '0;
                r_falla   <= 1'b0;
            end else if (w_invalida) begin
                if (r_err_cnt != C_ERR_MAX) begin
                    r_err_cnt <= r_err_cnt + EW'(1);
                end
                if (w_falla_nueva) begin
                    r_falla <= 1'b1;
                end
            end

            // Setting takes precedence over a simultaneous clear.
            if (w_invalida) begin
                r_err <= 1'b1;
            end else if (bus.clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.temp_registrado = r_temp;
    assign bus.per_bajo        = r_per_bajo;
    assign bus.per_alto        = r_per_alto;
    assign bus.falla_sensor    = r_falla;
    assign bus.err_sensor      = r_err;
    assign bus.cnt_bajo        = w_cnt_bajo;
    assign bus.cnt_alto        = w_cnt_alto;

endmodule
`default_nettype wire

// File: tb/tb_persistencia_temp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_persistencia_temp
//  Purpose  : Self-checking bench for persistencia_temp. Directed scenarios
//             plus a randomized run, all compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_persistencia_temp;

    import temp_pkg::*;

    localparam int N     = 8;
    localparam int EM    = 4;
    localparam int BAJO  = 180;
    localparam int ALTO  = 259;
    localparam int TMIN  = -400;
    localparam int TMAX  = 1250;
    localparam int TRST  = 220;

    logic clk;
    logic arst_n;

    int n_chk;
    int n_pass;

    // Behavioural reference state
    int m_reg, m_cb, m_ca, m_run;
    bit m_pb, m_pa, m_falla, m_err;

    persistencia_temp_if #(.N_PERSIST(N)) bus ();

    persistencia_temp #(
        .TEMP_BAJO  (BAJO),
        .TEMP_ALTO  (ALTO),
        .TEMP_MIN   (TMIN),
        .TEMP_MAX   (TMAX),
        .N_PERSIST  (N),
        .ERR_MAX    (EM),
        .TEMP_RESET (TRST)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    task automatic model_reset();
        m_reg = TRST; m_cb = 0; m_ca = 0; m_run = 0;
        m_pb = 0; m_pa = 0; m_falla = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input int t, input bit c);
        bit bad;
        bad = (t < TMIN) || (t > TMAX);
        if (c && !(v && bad)) m_err = 0;
        if (v) begin
            if (bad) begin
                m_err = 1;
                if (m_run < EM) m_run = m_run + 1;
                if (m_run == EM) begin
                    m_falla = 1; m_cb = 0; m_ca = 0;
                end
            end else begin
                m_reg = t; m_run = 0; m_falla = 0;
                if (t < BAJO) begin
                    m_cb = (m_cb < N) ? m_cb + 1 : N; m_ca = 0;
                end else if (t > ALTO) begin
                    m_ca = (m_ca < N) ? m_ca + 1 : N; m_cb = 0;
                end else begin
                    m_cb = 0; m_ca = 0;
                end
            end
            m_pb = (m_cb == N);
            m_pa = (m_ca == N);
        end
    endtask

    function automatic logic [21:0] exp_vec();
        temp_t r;
        r = temp_t'(m_reg);
        return {r, m_pb, m_pa, m_falla, m_err, 4'(m_cb), 4'(m_ca)};
    endfunction

    function automatic logic [21:0] obs_vec();
        return {bus.temp_registrado, bus.per_bajo, bus.per_alto,
                bus.falla_sensor, bus.err_sensor, bus.cnt_bajo, bus.cnt_alto};
    endfunction

    // One sample cycle: inputs applied at a falling edge, consumed on the
    // rising edge, outputs ready to observe at the next falling edge.
    task automatic drive(input bit v, input int t, input bit c);
        bus.temp_valid = v;
        bus.temp_in    = temp_t'(t);
        bus.clr_err    = c;
        @(posedge clk);
        model_step(v, t, c);
        @(negedge clk);
        bus.temp_valid = 1'b0;
        bus.clr_err    = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        arst_n = 1'b0;
        bus.temp_valid = 1'b0; bus.temp_in = '0; bus.clr_err = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_chk++;
            if (bus.temp_registrado !== 11'sd220 || bus.per_bajo !== 1'b0 ||
                bus.per_alto !== 1'b0 || bus.falla_sensor !== 1'b0 ||
                bus.err_sensor !== 1'b0 || bus.cnt_bajo !== 4'd0 || bus.cnt_alto !== 4'd0)
                $display("FAIL reset cyc %0d: got %h want %h", i, obs_vec(), {11'sd220, 11'd0});
            else n_pass++;
        end
    endtask

    task automatic test_cold_run();
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 150, 1'b0);
            n_chk++;
            if (obs_vec() !== exp_vec())
                $display("FAIL cold_run strobe %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (i == 7) begin
                n_chk++;
                if (bus.per_bajo !== 1'b0)
                    $display("FAIL cold_run early flag: got %b want 0", bus.per_bajo);
                else n_pass++;
            end
            if (i >= 8) begin
                n_chk++;
                if (bus.per_bajo !== 1'b1 || bus.cnt_bajo !== 4'd8)
                    $display("FAIL cold_run sat %0d: got %b/%0d want 1/8", i, bus.per_bajo, bus.cnt_bajo);
                else n_pass++;
            end
        end
        drive(1'b1, 200, 1'b0);
        n_chk++;
        if (bus.per_bajo !== 1'b0 || bus.cnt_bajo !== 4'd0 || obs_vec() !== exp_vec())
            $display("FAIL cold_run normal: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_hot_to_cold();
        for (int i = 0; i < 7; i++) drive(1'b1, 300, 1'b0);
        drive(1'b1, 100, 1'b0);
        n_chk++;
        if (bus.per_alto !== 1'b0 || bus.cnt_alto !== 4'd0 || bus.cnt_bajo !== 4'd1)
            $display("FAIL hot_to_cold switch: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
        for (int i = 0; i < 7; i++) drive(1'b1, 100, 1'b0);
        n_chk++;
        if (bus.per_bajo !== 1'b1 || obs_vec() !== exp_vec())
            $display("FAIL hot_to_cold flag: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    // 2000 does not fit the 11-bit signed port; -1000 is an equally
    // implausible reading that the port can carry.
    task automatic test_glitch_in_run();
        for (int i = 0; i < 5; i++) drive(1'b1, 300, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, -1000, 1'b0);
            n_chk++;
            if (bus.temp_registrado !== 11'sd300 || bus.err_sensor !== 1'b1 || bus.cnt_alto !== 4'd5)
                $display("FAIL glitch hold %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 300, 1'b0);
            n_chk++;
            if (bus.per_alto !== (i == 3) || obs_vec() !== exp_vec())
                $display("FAIL glitch resume %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_sensor_fault();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, -500, 1'b0);
            n_chk++;
            if (obs_vec() !== exp_vec() || bus.falla_sensor !== (i == 4))
                $display("FAIL fault step %0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (bus.cnt_alto !== 4'd0 || bus.per_alto !== 1'b0)
            $display("FAIL fault clears run: got %0d/%b want 0/0", bus.cnt_alto, bus.per_alto);
        else n_pass++;
        drive(1'b1, 220, 1'b0);
        n_chk++;
        if (bus.falla_sensor !== 1'b0 || obs_vec() !== exp_vec())
            $display("FAIL fault recover: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_clr_and_async_reset();
        drive(1'b0, 0, 1'b1);
        n_chk++;
        if (bus.err_sensor !== 1'b0)
            $display("FAIL clr_alone_1: got %b want 0", bus.err_sensor);
        else n_pass++;
        drive(1'b1, -700, 1'b1);
        n_chk++;
        if (bus.err_sensor !== 1'b1 || obs_vec() !== exp_vec())
            $display("FAIL clr_vs_set: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
        drive(1'b0, 0, 1'b1);
        n_chk++;
        if (bus.err_sensor !== 1'b0 || obs_vec() !== exp_vec())
            $display("FAIL clr_alone_2: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
        for (int i = 0; i < 5; i++) drive(1'b1, 100, 1'b0);
        n_chk++;
        if (bus.cnt_bajo !== 4'd5)
            $display("FAIL pre_reset count: got %0d want 5", bus.cnt_bajo);
        else n_pass++;
        #2 arst_n = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if (bus.cnt_bajo !== 4'd0 || bus.temp_registrado !== 11'sd220 || obs_vec() !== exp_vec())
            $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
        @(negedge clk);
        arst_n = 1'b1;
        drive(1'b1, 100, 1'b0);
        n_chk++;
        if (bus.cnt_bajo !== 4'd1 || obs_vec() !== exp_vec())
            $display("FAIL restart count: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_boundaries();
        int vals [8];
        vals = '{179, 180, 259, 260, -400, -401, 1023, -1024};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vals[i], 1'b0);
            n_chk++;
            if (obs_vec() !== exp_vec())
                $display("FAIL boundary %0d: got %h want %h", vals[i], obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int t;
        int cat;
        bit v;
        bit c;
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 4) != 0);
            c   = ($urandom_range(0, 15) == 0);
            cat = $urandom_range(0, 9);
            if (cat <= 3)      t = $urandom_range(0, 579) - 400;   // cold
            else if (cat <= 6) t = $urandom_range(260, 1023);      // hot
            else if (cat == 7) t = $urandom_range(180, 259);       // normal
            else               t = $urandom_range(0, 623) - 1024;  // invalid
            drive(v, t, c);
            n_chk++;
            if (obs_vec() !== exp_vec())
                $display("FAIL random %0d (v=%0b t=%0d c=%0b): got %h want %h",
                         i, v, t, c, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_cold_run();
        test_hot_to_cold();
        test_glitch_in_run();
        test_sensor_fault();
        test_clr_and_async_reset();
        test_boundaries();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
